// File: rtl/babbage_pkg.sv
// Shared definitions for the Babbage polynomial f(n) = 2n^2 + 3n + 5
// used by both the forward difference engine and its inverse solver.
package babbage_pkg;

  localparam int unsigned COEF_A = 2;
  localparam int unsigned COEF_B = 3;
  localparam int unsigned COEF_C = 5;
  localparam int unsigned DIFF2  = 2 * COEF_A;

  // Bits needed to hold f(MAX_NUM) where MAX_NUM = 2^in_width - 1.
  function automatic int unsigned out_width(input int unsigned in_width);
    int unsigned m;
    m = (32'd1 << in_width) - 32'd1;
    return $clog2(COEF_A * m * m + COEF_B * m + COEF_C);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } babbage_state_e;

endpackage

// File: rtl/babbage_inverse.sv
// Inverse solver: largest n in [0, MAX_NUM] with f(n) <= y, found by
// walking forward differences upward from n = 0 using additions only.
module babbage_inverse
  import babbage_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [out_width(IN_WIDTH)-1:0]       y,
  output logic [IN_WIDTH-1:0]                  n_out,
  output logic                                 exact,
  output logic                                 found,
  output logic                                 done,
  output logic                                 rdy
);

  localparam int unsigned OUT_WIDTH = out_width(IN_WIDTH);

  babbage_state_e          state_q;
  logic [OUT_WIDTH-1:0]    y_q;
  logic [OUT_WIDTH-1:0]    f_q;
  logic [OUT_WIDTH-1:0]    d_q;
  logic [IN_WIDTH-1:0]     n_q;
  logic [IN_WIDTH-1:0]     n_out_q;
  logic                    exact_q;
  logic                    found_q;
  logic                    done_q;
  logic                    rdy_q;

  logic [OUT_WIDTH:0]      next_f;
  logic                    stop;
  logic                    has_solution;

  // One extra bit so f(MAX_NUM) + d cannot wrap before the compare.
  always_comb begin
    next_f       = {1'b0, f_q} + {1'b0, d_q};
    stop         = (n_q == '1) || (next_f > {1'b0, y_q});
    has_solution = (y_q >= OUT_WIDTH'(COEF_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      f_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      n_out_q <= '0;
      exact_q <= 1'b0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            y_q     <= y;
            f_q     <= OUT_WIDTH'(COEF_C);
            d_q     <= OUT_WIDTH'(COEF_A + COEF_B);
            n_q     <= '0;
            rdy_q   <= 1'b0;
            state_q <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (stop) begin
            n_out_q <= has_solution ? n_q : '0;
            found_q <= has_solution;
            exact_q <= has_solution && (f_q == y_q);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            f_q <= next_f[OUT_WIDTH-1:0];
            d_q <= d_q + OUT_WIDTH'(DIFF2);
            n_q <= n_q + IN_WIDTH'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign n_out = n_out_q;
  assign exact = exact_q;
  assign found = found_q;
  assign done  = done_q;
  assign rdy   = rdy_q;

endmodule

// File: tb/tb_babbage_inverse.sv
// Directed-vector bench for babbage_inverse with hand-computed results.
module tb_babbage_inverse;

  localparam int unsigned IN_W  = 5;
  localparam int unsigned OUT_W = 11;

  logic              clk;
  logic              rst;
  logic              start;
  logic [OUT_W-1:0]  y;
  logic [IN_W-1:0]   n_out;
  logic              exact;
  logic              found;
  logic              done;
  logic              rdy;

  int unsigned n_cmp;
  int unsigned n_bad;

  babbage_inverse #(.IN_WIDTH(IN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .y     (y),
    .n_out (n_out),
    .exact (exact),
    .found (found),
    .done  (done),
    .rdy   (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after an edge while idle; returns #1 after the edge where done is seen.
  // Latency counts edges from the accepting edge to the first edge sampling done high.
  task automatic request(input int unsigned yv, output int unsigned lat);
    int unsigned c;
    y     = OUT_W'(yv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("rdy_low_y%0d", yv), rdy, 0);
    c = 1;
    while (done !== 1'b1 && c < 60) begin
      @(posedge clk); #1;
      if (done !== 1'b1) c++;
    end
    if (done !== 1'b1) begin
      check($sformatf("done_timeout_y%0d", yv), 0, 1);
      lat = 0;
    end else begin
      lat = c + 1;
    end
  endtask

  typedef struct {
    int unsigned yv;
    int unsigned n;
    int unsigned ex;
    int unsigned fd;
    int unsigned lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int unsigned lat;
    int unsigned pulses;

    vecs[0] = '{19,   2,  1, 1, 4};
    vecs[1] = '{25,   2,  0, 1, 4};
    vecs[2] = '{4,    0,  0, 0, 2};
    vecs[3] = '{5,    0,  1, 1, 2};
    vecs[4] = '{9,    0,  0, 1, 2};
    vecs[5] = '{2020, 31, 1, 1, 33};
    vecs[6] = '{2047, 31, 0, 1, 33};

    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    start = 1'b0;
    y     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_rdy",   rdy,   1);
    check("reset_done",  done,  0);
    check("reset_n_out", n_out, 0);
    check("reset_exact", exact, 0);
    check("reset_found", found, 0);

    // Each request is issued in the first rdy cycle after the previous done.
    foreach (vecs[i]) begin
      request(vecs[i].yv, lat);
      check($sformatf("n_out_y%0d", vecs[i].yv), n_out, vecs[i].n);
      check($sformatf("exact_y%0d", vecs[i].yv), exact, vecs[i].ex);
      check($sformatf("found_y%0d", vecs[i].yv), found, vecs[i].fd);
      check($sformatf("lat_y%0d",   vecs[i].yv), lat,   vecs[i].lat);
      @(posedge clk); #1;
      check($sformatf("done_pulse_y%0d", vecs[i].yv), done, 0);
      check($sformatf("rdy_back_y%0d",   vecs[i].yv), rdy,  1);
      check($sformatf("hold_n_y%0d",     vecs[i].yv), n_out, vecs[i].n);
    end

    // Start during SEARCH must be ignored.
    y     = 11'd2047;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    y     = 11'd19;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignored_start_done", done, 1);
    check("ignored_start_n",    n_out, 31);
    check("ignored_start_ex",   exact, 0);
    @(posedge clk); #1;

    // Reset mid-search abandons the request without a done pulse.
    y     = 11'd2047;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rdy",   rdy,   1);
    check("midrst_done",  done,  0);
    check("midrst_n_out", n_out, 0);
    check("midrst_exact", exact, 0);
    check("midrst_found", found, 0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 0);

    request(19, lat);
    check("after_rst_n",     n_out, 2);
    check("after_rst_exact", exact, 1);
    check("after_rst_found", found, 1);
    check("after_rst_lat",   lat,   4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
